// File: rtl/prog_loader.sv
// Program-memory writer: streams bytes from a valid/ready input into a 2**AW x DW memory,
// starting at a loaded base for a programmed length, with running checksum and status.
module prog_loader #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [AW:0]   i_len,
    input  logic          i_abort,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_data,
    output logic          o_in_ready,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_checksum,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_wr_addr;
    logic [AW:0]   r_remaining;
    logic [DW-1:0] r_checksum;
    logic          r_aborted;
    logic [DW-1:0] r_mem [0:(2**AW)-1];

    logic w_xfer;
    logic w_start_ok;
    logic w_abort_ok;

    // abort takes priority over a byte presented in the same cycle
    assign w_xfer     = (r_state == S_LOAD) && i_in_valid && !i_abort;
    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_abort_ok = (r_state == S_LOAD) && i_abort;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_len != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_xfer && (r_remaining == (AW+1)'(1))) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wr_addr   <= '0;
            r_remaining <= '0;
            r_checksum  <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_wr_addr   <= i_base;
                r_remaining <= i_len;
                r_checksum  <= '0;
                r_aborted   <= 1'b0;
            end else if (w_abort_ok) begin
                r_aborted <= 1'b1;
            end else if (w_xfer) begin
                r_wr_addr   <= r_wr_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
                r_checksum  <= r_checksum + i_in_data;
            end
        end
    end

    // memory has no reset so contents survive a mid-session reset
    always_ff @(posedge i_clk) begin
        if (w_xfer) begin
            r_mem[r_wr_addr] <= i_in_data;
        end
    end

    assign o_rd_data  = r_mem[i_rd_addr];
    assign o_in_ready = (r_state == S_LOAD);
    assign o_busy     = (r_state == S_LOAD);
    assign o_done     = (r_state == S_DONE);
    assign o_wr_addr  = r_wr_addr;
    assign o_checksum = r_checksum;
    assign o_aborted  = r_aborted;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program memory. The fetch path reads instructions from this memory through a combinational read port.
- Accepts a byte stream over a valid/ready handshake and writes it into an internal 4K x 8 memory. Writes start at a loadable base address and run for a programmed length.
- Keeps a running 8-bit checksum of the loaded bytes. Reports busy, done and abort status to the controlling logic.

Parameters:
- AW, 12, address width; memory depth = 2**AW locations.
- DW, 8, data width of each memory word and of each stream byte.

Ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begins a load session; sampled in IDLE only.
- base  input  AW  first write address; sampled with start.
- len  input  AW+1  number of bytes to load, 0..4096; sampled with start.
- abort  input  1  cancels the active session.
- in_valid  input  1  stream byte present.
- in_data  input  DW  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- rd_addr  input  AW  fetch-side read address.
- rd_data  output  DW  combinational read of mem[rd_addr].
- wr_addr  output  AW  next write address.
- checksum  output  DW  mod-2**DW sum of bytes accepted this session.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when a session completes.
- aborted  output  1  sticky; set by abort, cleared by the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wr_addr=0, remaining=0, checksum=0.
  - busy=0, done=0, aborted=0, in_ready=0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: wr_addr<=base, remaining<=len, checksum<=0, aborted<=0; next state LOAD.
  - start=1 with len==0: wr_addr<=base, checksum<=0, aborted<=0; next state DONE. No memory write occurs.
- LOAD:
  - busy=1 and in_ready=1; in_ready is a registered function of state.
  - A transfer occurs on a rising edge where in_valid=1, in_ready=1 and abort=0.
  - On each transfer: mem[wr_addr]<=in_data; wr_addr<=wr_addr+1; checksum<=checksum+in_data (truncated to DW); remaining<=remaining-1.
  - If a transfer occurs with remaining==1, next state is DONE.
  - in_valid=0 means a stall: nothing changes.
- DONE:
  - done=1 for exactly one cycle; next state IDLE.
  - wr_addr and checksum hold their final values until the next start.
- Address wrap: wr_addr 4095+1 -> 0. A load with base=4090, len=10 writes addresses 4090..4095, then 0..3.
- len=4096 fills the whole memory exactly once.
- abort:
  - In LOAD: no write that cycle, even if in_valid=1. Next state IDLE; aborted<=1; busy drops next cycle; no done pulse.
  - Locations already written keep their new data.
  - abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored; it is not queued.
- Read port:
  - rd_data = mem[rd_addr], combinational.
  - A read of the address being written in the same cycle returns the old data; the new data is visible after the edge.
- Reset asserted mid-LOAD: session lost, outputs return to their reset values, written locations are retained.

Test Plan:
- Reset then start, base=0x000, len=4, bytes 0x11,0x22,0x33,0x44 with in_valid held high:
  - mem[0..3]=11,22,33,44; checksum=0xAA; done pulses one cycle after the 4th transfer; wr_addr=0x004.
- base=0xFFE, len=4, bytes 0x01..0x04:
  - mem[0xFFE]=01, mem[0xFFF]=02, mem[0x000]=03, mem[0x001]=04; wr_addr=0x002; checksum=0x0A.
- len=3, in_valid toggling 1,0,0,1,0,1 with bytes 0xF0,0x20,0x05:
  - exactly 3 writes; checksum=0x15 (wrapped); busy high throughout; done pulses once.
- Start len=5 at base=0x100, abort asserted with in_valid=1 on the 3rd byte:
  - mem[0x100..0x101] written, mem[0x102] unchanged; aborted=1; no done; in_ready=0 next cycle.
  - A later start clears aborted.
- start with len=0 at base=0x7A0:
  - done pulses after 1 cycle; no write; wr_addr=0x7A0; checksum=0.
  - start asserted during a LOAD session is ignored (remaining and wr_addr unaffected).
- reset pulled low for one cycle mid-LOAD after 2 of 6 bytes:
  - state IDLE, outputs at reset values; mem keeps the 2 written bytes, readable on rd_data.
